// File: rtl/hazard_ctrl_pkg.sv
// Shared codes and helpers for the D-stage hazard scheduler.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] MD_NONE = 2'd0;
  localparam logic [1:0] MD_MULT = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_USE  = 2'd3;

  function automatic logic [2:0] sat_dec(input logic [2:0] x);
    return (x == 3'd0) ? 3'd0 : x - 3'd1;
  endfunction

  // Youngest matching producer decides; a not-yet-ready young match hides older copies.
  function automatic logic [1:0] fwd_pick(input logic [4:0] a,
                                          input logic [4:0] e_a3, input logic [2:0] e_tnew,
                                          input logic [4:0] m_a3, input logic [2:0] m_tnew,
                                          input logic [4:0] w_a3);
    if (a == 5'd0)  return FWD_RF;
    if (a == e_a3)  return (e_tnew == 3'd0) ? FWD_E : FWD_RF;
    if (a == m_a3)  return (m_tnew == 3'd0) ? FWD_M : FWD_RF;
    if (a == w_a3)  return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic reg_hazard(input logic [4:0] a, input logic [2:0] tuse,
                                      input logic [4:0] e_a3, input logic [2:0] e_tnew,
                                      input logic [4:0] m_a3, input logic [2:0] m_tnew);
    return (a != 5'd0) && (((a == e_a3) && (e_tnew > tuse)) ||
                           ((a == m_a3) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Countdown timer for the mult/div unit; busy while the count is nonzero.
module md_busy_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = load_val;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// D-stage stall/forward scheduler: tracks E/M/W producers and the mult/div busy window.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_a1,
  input  logic [4:0] d_a2,
  input  logic [4:0] d_a3,
  input  logic [2:0] d_tnew,
  input  logic [2:0] d_tuse1,
  input  logic [2:0] d_tuse2,
  input  logic [1:0] d_md_op,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_sel1,
  output logic [1:0] fwd_sel2,
  output logic       md_busy,
  output logic [4:0] e_a3,
  output logic [4:0] m_a3,
  output logic [4:0] w_a3,
  output logic [2:0] e_tnew,
  output logic [2:0] m_tnew
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  logic [4:0] e_a3_q, e_a3_d, m_a3_q, m_a3_d, w_a3_q, w_a3_d;
  logic [2:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
  logic       e_md_start_q, e_md_start_d;
  logic       md_is_start, md_load, reg_stall, md_stall;
  logic [CNT_W-1:0] md_len;

  assign reg_stall = reg_hazard(d_a1, d_tuse1, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q) |
                     reg_hazard(d_a2, d_tuse2, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
  // e_md_start covers the edge where the op entered E, in case the timer is not yet visible.
  assign md_stall  = (d_md_op != MD_NONE) && (md_busy || e_md_start_q);
  assign stall     = reg_stall | md_stall;

  assign fwd_sel1 = fwd_pick(d_a1, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
  assign fwd_sel2 = fwd_pick(d_a2, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);

  assign md_is_start = (d_md_op == MD_MULT) || (d_md_op == MD_DIV);
  assign md_load     = md_is_start && !stall && !flush;
  assign md_len      = (d_md_op == MD_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_comb begin
    e_a3_d       = stall ? 5'd0 : d_a3;
    e_tnew_d     = stall ? 3'd0 : sat_dec(d_tnew);
    m_a3_d       = e_a3_q;
    m_tnew_d     = sat_dec(e_tnew_q);
    w_a3_d       = m_a3_q;
    e_md_start_d = md_load;
    if (flush) begin
      e_a3_d   = 5'd0;
      e_tnew_d = 3'd0;
      m_a3_d   = 5'd0;
      m_tnew_d = 3'd0;
      w_a3_d   = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_a3_q       <= 5'd0;
      e_tnew_q     <= 3'd0;
      m_a3_q       <= 5'd0;
      m_tnew_q     <= 3'd0;
      w_a3_q       <= 5'd0;
      e_md_start_q <= 1'b0;
    end else begin
      e_a3_q       <= e_a3_d;
      e_tnew_q     <= e_tnew_d;
      m_a3_q       <= m_a3_d;
      m_tnew_q     <= m_tnew_d;
      w_a3_q       <= w_a3_d;
      e_md_start_q <= e_md_start_d;
    end
  end

  md_busy_timer #(.W(CNT_W)) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (md_load),
    .load_val (md_len),
    .busy     (md_busy)
  );

  assign e_a3   = e_a3_q;
  assign m_a3   = m_a3_q;
  assign w_a3   = w_a3_q;
  assign e_tnew = e_tnew_q;
  assign m_tnew = m_tnew_q;

endmodule
